// File: rtl/zx_audio_pkg.sv
// Shared types and constants for the ZX audio mixer: stereo modes, beeper
// weights, mix width and the sequencing FSM states.
package zx_audio_pkg;

  localparam int unsigned MIX_W     = 10;
  localparam int unsigned BEEP_EAR  = 128;
  localparam int unsigned BEEP_MIC  = 64;
  localparam int unsigned BEEP_TAPE = 32;

  typedef enum logic [1:0] {
    MODE_MONO = 2'd0,
    MODE_ABC  = 2'd1,
    MODE_ACB  = 2'd2
  } stereo_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MIX_L,
    ST_MIX_R,
    ST_FILT,
    ST_OUT
  } state_e;

  // Encoding 3 is folded onto ABC so downstream logic only sees legal modes.
  function automatic stereo_e decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_MONO;
      2'd2:    return MODE_ACB;
      default: return MODE_ABC;
    endcase
  endfunction

endpackage

// File: rtl/zx_audio_lpf.sv
// One-pole low-pass filter with clamped unsigned output. code_o is the clamp
// of the state value the next upd_i strobe will store, so it is sampled with it.
module zx_audio_lpf
  import zx_audio_pkg::*;
#(
  parameter int unsigned MSBI       = 9,
  parameter int unsigned FILT_SHIFT = 3
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             upd_i,
  input  logic [MIX_W-1:0] x_i,
  output logic [MSBI:0]    code_o
);

  localparam int unsigned XSH = (MSBI < 9) ? (9 - MSBI) : 0;
  localparam int unsigned YW  = MSBI + FILT_SHIFT + 3;
  localparam logic signed [YW-1:0] CODE_MAX = YW'((2 ** (MSBI + 1)) - 1);

  logic [MIX_W-1:0]     x_s;
  logic signed [YW-1:0] x_fx;
  logic signed [YW-1:0] y_q;
  logic signed [YW-1:0] y_d;
  logic signed [YW-1:0] int_d;

  assign x_s = x_i >> XSH;

  always_comb begin
    x_fx   = signed'(YW'(x_s)) <<< FILT_SHIFT;
    y_d    = y_q + ((x_fx - y_q) >>> FILT_SHIFT);
    int_d  = y_d >>> FILT_SHIFT;
    code_o = '0;
    if (int_d[YW-1]) begin
      code_o = '0;
    end else if (int_d > CODE_MAX) begin
      code_o = '1;
    end else begin
      code_o = int_d[MSBI:0];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      y_q <= '0;
    end else if (upd_i) begin
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/zx_audio_mixer.sv
// Stereo mixer: latches PSG/beeper sources on ce, forms L/R through one shared
// adder, low-pass filters each channel and presents codes to the DACs.
module zx_audio_mixer
  import zx_audio_pkg::*;
#(
  parameter int unsigned MSBI       = 9,
  parameter int unsigned FILT_SHIFT = 3
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce,
  input  logic [7:0]    psg_a,
  input  logic [7:0]    psg_b,
  input  logic [7:0]    psg_c,
  input  logic          ear,
  input  logic          mic,
  input  logic          tape_in,
  input  logic [1:0]    stereo_mode,
  input  logic          mute,
  output logic [MSBI:0] dac_l,
  output logic [MSBI:0] dac_r,
  output logic          sample_valid
);

  state_e           state_q;
  stereo_e          mode_q;
  logic [7:0]       a_q, b_q, c_q;
  logic             ear_q, mic_q, tape_q, mute_q;
  logic [MIX_W-1:0] mix_l_q, mix_r_q;
  logic [MSBI:0]    dac_l_q, dac_r_q;
  logic             valid_q;

  logic [7:0]       op_p, op_q, op_r;
  logic [MIX_W-1:0] beep;
  logic [MIX_W-1:0] mix_sum;
  logic [MSBI:0]    code_l, code_r;

  // Every mode reduces to p + q + r + beep; the doubled channel is fed twice.
  always_comb begin
    op_p = '0;
    op_q = '0;
    op_r = '0;
    case (mode_q)
      MODE_MONO: begin
        op_p = a_q; op_q = b_q; op_r = c_q;
      end
      MODE_ACB: begin
        if (state_q == ST_MIX_R) begin
          op_p = b_q; op_q = b_q; op_r = c_q;
        end else begin
          op_p = a_q; op_q = a_q; op_r = c_q;
        end
      end
      default: begin
        if (state_q == ST_MIX_R) begin
          op_p = c_q; op_q = c_q; op_r = b_q;
        end else begin
          op_p = a_q; op_q = a_q; op_r = b_q;
        end
      end
    endcase
    beep = (ear_q  ? MIX_W'(BEEP_EAR)  : '0)
         + (mic_q  ? MIX_W'(BEEP_MIC)  : '0)
         + (tape_q ? MIX_W'(BEEP_TAPE) : '0);
    mix_sum = mute_q ? '0
            : MIX_W'(op_p) + MIX_W'(op_q) + MIX_W'(op_r) + beep;
  end

  zx_audio_lpf #(.MSBI(MSBI), .FILT_SHIFT(FILT_SHIFT)) u_lpf_l (
    .clk_sys (clk_sys),
    .reset   (reset),
    .upd_i   (state_q == ST_FILT),
    .x_i     (mix_l_q),
    .code_o  (code_l)
  );

  zx_audio_lpf #(.MSBI(MSBI), .FILT_SHIFT(FILT_SHIFT)) u_lpf_r (
    .clk_sys (clk_sys),
    .reset   (reset),
    .upd_i   (state_q == ST_FILT),
    .x_i     (mix_r_q),
    .code_o  (code_r)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MONO;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      ear_q   <= 1'b0;
      mic_q   <= 1'b0;
      tape_q  <= 1'b0;
      mute_q  <= 1'b0;
      mix_l_q <= '0;
      mix_r_q <= '0;
      dac_l_q <= '0;
      dac_r_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ce) begin
            mode_q  <= decode_mode(stereo_mode);
            a_q     <= psg_a;
            b_q     <= psg_b;
            c_q     <= psg_c;
            ear_q   <= ear;
            mic_q   <= mic;
            tape_q  <= tape_in;
            mute_q  <= mute;
            state_q <= ST_MIX_L;
          end
        end
        ST_MIX_L: begin
          mix_l_q <= mix_sum;
          state_q <= ST_MIX_R;
        end
        ST_MIX_R: begin
          mix_r_q <= mix_sum;
          state_q <= ST_FILT;
        end
        // Filters commit on this edge; their codes are captured alongside.
        ST_FILT: begin
          dac_l_q <= code_l;
          dac_r_q <= code_r;
          valid_q <= 1'b1;
          state_q <= ST_OUT;
        end
        ST_OUT:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dac_l        = dac_l_q;
  assign dac_r        = dac_r_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_zx_audio_mixer.sv
// Randomised check of zx_audio_mixer with an unfiltered (FILT_SHIFT=0) and a
// filtered (FILT_SHIFT=2) instance driven from the same sources.
module tb_zx_audio_mixer;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ce      = 1'b0;
  logic [7:0] psg_a = '0, psg_b = '0, psg_c = '0;
  logic       ear = 1'b0, mic = 1'b0, tape_in = 1'b0, mute = 1'b0;
  logic [1:0] stereo_mode = '0;

  logic [9:0] dl0, dr0, dl2, dr2;
  logic       sv0, sv2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  longint y_l = 0, y_r = 0;
  longint exp_l0 = 0, exp_r0 = 0, exp_l2 = 0, exp_r2 = 0;

  always #5 clk_sys = ~clk_sys;

  zx_audio_mixer #(.MSBI(9), .FILT_SHIFT(0)) u_fs0 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce),
    .psg_a(psg_a), .psg_b(psg_b), .psg_c(psg_c),
    .ear(ear), .mic(mic), .tape_in(tape_in),
    .stereo_mode(stereo_mode), .mute(mute),
    .dac_l(dl0), .dac_r(dr0), .sample_valid(sv0)
  );

  zx_audio_mixer #(.MSBI(9), .FILT_SHIFT(2)) u_fs2 (
    .clk_sys(clk_sys), .reset(reset), .ce(ce),
    .psg_a(psg_a), .psg_b(psg_b), .psg_c(psg_c),
    .ear(ear), .mic(mic), .tape_in(tape_in),
    .stereo_mode(stereo_mode), .mute(mute),
    .dac_l(dl2), .dac_r(dr2), .sample_valid(sv2)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clamp10(input longint v);
    if (v < 0) return 0;
    if (v > 1023) return 1023;
    return v;
  endfunction

  // Reference: spec mix formulas, then y += ((x*4) - y) / 4 rounded toward -inf.
  task automatic model_step(input int a, input int b, input int c, input bit e,
                            input bit m, input bit t, input int mode, input bit mu);
    longint beep, l, r;
    beep = (e ? 128 : 0) + (m ? 64 : 0) + (t ? 32 : 0);
    case (mode)
      0:       begin l = a + b + c + beep;  r = l;                end
      2:       begin l = 2*a + c + beep;    r = 2*b + c + beep;   end
      default: begin l = 2*a + b + beep;    r = 2*c + b + beep;   end
    endcase
    if (mu) begin l = 0; r = 0; end
    exp_l0 = clamp10(l);
    exp_r0 = clamp10(r);
    y_l = y_l + ((l * 4 - y_l) >>> 2);
    y_r = y_r + ((r * 4 - y_r) >>> 2);
    exp_l2 = clamp10(y_l >>> 2);
    exp_r2 = clamp10(y_r >>> 2);
  endtask

  task automatic model_reset();
    y_l = 0; y_r = 0;
    exp_l0 = 0; exp_r0 = 0; exp_l2 = 0; exp_r2 = 0;
  endtask

  task automatic scramble();
    psg_a = 8'($urandom); psg_b = 8'($urandom); psg_c = 8'($urandom);
    ear = 1'($urandom); mic = 1'($urandom); tape_in = 1'($urandom);
    stereo_mode = 2'($urandom); mute = 1'($urandom);
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_l0"}, dl0, exp_l0);
    check({tag, "_r0"}, dr0, exp_r0);
    check({tag, "_l2"}, dl2, exp_l2);
    check({tag, "_r2"}, dr2, exp_r2);
  endtask

  // Caller is at a negedge; returns at the negedge five cycles later, the
  // earliest point at which the next ce may be issued.
  task automatic run_sample(input int a, input int b, input int c, input bit e,
                            input bit m, input bit t, input int mode, input bit mu,
                            input bit glitch);
    psg_a = 8'(a); psg_b = 8'(b); psg_c = 8'(c);
    ear = e; mic = m; tape_in = t; stereo_mode = 2'(mode); mute = mu;
    ce = 1'b1;
    @(negedge clk_sys);
    ce = 1'b0;
    scramble();
    check("busy1_v0", sv0, 0);
    check("busy1_v2", sv2, 0);
    @(negedge clk_sys);
    if (glitch) begin
      scramble();
      ce = 1'b1;
    end
    check("busy2_v0", sv0, 0);
    @(negedge clk_sys);
    ce = 1'b0;
    check("busy3_v0", sv0, 0);
    model_step(a, b, c, e, m, t, mode, mu);
    @(negedge clk_sys);
    check("out_v0", sv0, 1);
    check("out_v2", sv2, 1);
    check_outs("out");
    @(negedge clk_sys);
    check("idle_v0", sv0, 0);
    check("idle_v2", sv2, 0);
    check_outs("hold");
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    model_reset();
    check("rst_v0", sv0, 0);
    check("rst_v2", sv2, 0);
    check_outs("rst");
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk_sys);
    apply_reset();

    // ABC, A full scale plus EAR.
    run_sample(255, 0, 0, 1, 0, 0, 1, 0, 0);
    check("abc_l", dl0, 638);
    check("abc_r", dr0, 128);

    // ACB with no beeper.
    run_sample(0, 100, 50, 0, 0, 0, 2, 0, 0);
    check("acb_l", dl0, 50);
    check("acb_r", dr0, 250);

    // Mono full scale, then mute.
    run_sample(255, 255, 255, 1, 1, 1, 0, 0, 0);
    check("mono_l", dl0, 989);
    check("mono_r", dr0, 989);
    run_sample(255, 255, 255, 1, 1, 1, 0, 1, 0);
    check("mute_l", dl0, 0);
    check("mute_r", dr0, 0);

    // Step response of the filtered instance to a 400 target.
    apply_reset();
    run_sample(200, 0, 200, 0, 0, 0, 1, 0, 0);
    check("step1", dl2, 100);
    run_sample(200, 0, 200, 0, 0, 0, 1, 0, 0);
    check("step2", dl2, 175);
    run_sample(200, 0, 200, 0, 0, 0, 1, 0, 0);
    check("step3", dl2, 231);
    run_sample(200, 0, 200, 0, 0, 0, 1, 0, 0);
    check("step4", dl2, 273);

    // ce during a sequence is ignored; back-to-back at +5 is accepted.
    run_sample(10, 20, 30, 0, 1, 0, 3, 0, 1);
    run_sample(40, 50, 60, 1, 0, 1, 2, 0, 1);

    // Reset in the middle of a sequence.
    scramble();
    ce = 1'b1;
    @(negedge clk_sys);
    ce = 1'b0;
    @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      check("abort_v0", sv0, 0);
      check("abort_v2", sv2, 0);
      check_outs("abort");
      @(negedge clk_sys);
    end
    run_sample(77, 33, 11, 1, 0, 0, 1, 0, 0);

    for (int n = 0; n < 60; n++) begin
      run_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
